// File: rtl/pt_filter_pkg.sv
// Shared constants, FSM state type and output narrowing for the Pan-Tompkins filter stages.
// Define HPF_SATURATE_EN to clamp the high-pass result; otherwise it wraps.
package pt_filter_pkg;

    localparam int HPF_TAPS   = 32;
    localparam int HPF_CENTER = 16;
    localparam int HPF_SHIFT  = 5;
    localparam int HPF_MAXW   = 32;

    typedef enum logic {
        FILL,
        RUN
    } hpf_state_t;

    // Narrows r to dw bits, returned sign-extended in HPF_MAXW bits.
    function automatic logic signed [HPF_MAXW-1:0] hpf_narrow(
        input logic signed [HPF_MAXW-1:0] r,
        input int unsigned                dw
    );
`ifdef HPF_SATURATE_EN
        logic signed [HPF_MAXW-1:0] hi;
        logic signed [HPF_MAXW-1:0] lo;
        hi = (HPF_MAXW'(1) <<< (dw - 1)) - HPF_MAXW'(1);
        lo = -hi - HPF_MAXW'(1);
        if (r > hi) begin
            return hi;
        end else if (r < lo) begin
            return lo;
        end
        return r;
`else
        return (r <<< (HPF_MAXW - dw)) >>> (HPF_MAXW - dw);
`endif
    endfunction

endpackage

// File: rtl/sample_delay_line.sv
// Parameterised shift-register delay line with shift enable, sync clear and async reset.
// Exposes one configurable centre tap and the oldest tap.
module sample_delay_line #(
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned CENTER_TAP = 15
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_shift,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_tap_center,
    output logic [WIDTH-1:0] o_tap_last
);

    logic [WIDTH-1:0] r_line [DEPTH];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_line[i] <= '0;
        end else if (i_clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_line[i] <= '0;
        end else if (i_shift) begin
            r_line[0] <= i_din;
            for (int unsigned i = 1; i < DEPTH; i++) r_line[i] <= r_line[i-1];
        end
    end

    assign o_tap_center = r_line[CENTER_TAP];
    assign o_tap_last   = r_line[DEPTH-1];

endmodule

// File: rtl/high_pass_filter.sv
// Pan-Tompkins high-pass stage: y(n) = x(n-16) - (1/32)*sum(x(n-k), k=0..31), valid/ready streaming.
// Define HPF_SATURATE_EN to saturate instead of wrapping the narrowed output.
module high_pass_filter
    import pt_filter_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         en,
    input  logic                         clr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] xin,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] yout
);

    localparam int SUM_W = DATA_WIDTH + HPF_SHIFT;
    localparam int RES_W = DATA_WIDTH + 2;
    localparam int CNT_W = $clog2(HPF_TAPS) + 1;

    logic                         w_accept;
    logic                         w_load;
    logic signed [DATA_WIDTH-1:0] w_tap_center;
    logic signed [DATA_WIDTH-1:0] w_tap_last;
    logic signed [SUM_W-1:0]      w_sum_next;
    logic signed [SUM_W-1:0]      w_avg;
    logic signed [RES_W-1:0]      w_result;
    logic signed [SUM_W-1:0]      r_sum;
    logic [CNT_W-1:0]             r_count;
    hpf_state_t                   r_state;
    hpf_state_t                   w_state_next;
    logic                         r_out_valid;
    logic signed [DATA_WIDTH-1:0] r_yout;

    assign in_ready  = rstn && en && !clr && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_load    = w_accept && (r_state == RUN);
    assign out_valid = r_out_valid;
    assign yout      = r_yout;

    sample_delay_line #(
        .DEPTH     (HPF_TAPS),
        .WIDTH     (DATA_WIDTH),
        .CENTER_TAP(HPF_CENTER - 1)
    ) u_delay (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_shift     (w_accept),
        .i_clr       (clr),
        .i_din       (xin),
        .o_tap_center(w_tap_center),
        .o_tap_last  (w_tap_last)
    );

    // Tap 15 before the shift is x(n-16) relative to the sample being accepted.
    assign w_sum_next = r_sum + SUM_W'(xin) - SUM_W'(w_tap_last);
    assign w_avg      = w_sum_next >>> HPF_SHIFT;
    assign w_result   = RES_W'(w_tap_center) - RES_W'(w_avg);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sum   <= '0;
            r_count <= '0;
        end else if (clr) begin
            r_sum   <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_sum <= w_sum_next;
            if (r_state == FILL) r_count <= r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= FILL;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (clr) begin
            w_state_next = FILL;
        end else if (w_accept && (r_state == FILL) && (r_count == CNT_W'(HPF_TAPS - 1))) begin
            w_state_next = RUN;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_yout      <= '0;
        end else if (clr) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_yout      <= DATA_WIDTH'(hpf_narrow(HPF_MAXW'(w_result), DATA_WIDTH));
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_high_pass_filter.sv
// Self-checking bench for high_pass_filter against a sample-history arithmetic model.
module tb_high_pass_filter;

    localparam int DW = 16;
`ifdef HPF_SATURATE_EN
    localparam int OVF_EXP = 32767;
`else
    localparam int OVF_EXP = -2048;
`endif

    logic clk = 1'b0;
    logic rstn, en, clr, in_valid, in_ready, out_valid, out_ready;
    logic signed [DW-1:0] xin, yout;

    int n_cmp = 0;
    int n_bad = 0;

    int   hist[$];
    int   m_count;
    logic m_valid;
    logic signed [DW-1:0] m_yout;
    logic m_rdy;
    logic m_loaded;
    logic s_rdy;
    int   got_q[$];
    int   exp_q[$];

    always #5 clk = ~clk;

    high_pass_filter #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .xin(xin),
        .out_valid(out_valid), .out_ready(out_ready), .yout(yout)
    );

    function automatic int fit(int r);
`ifdef HPF_SATURATE_EN
        if (r > 32767) return 32767;
        if (r < -32768) return -32768;
        return r;
`else
        return ((r + 32768) % 65536 + 65536) % 65536 - 32768;
`endif
    endfunction

    // x(n-16) minus floor of the mean of the newest 32 samples.
    function automatic int ref_y();
        int n, sum, q;
        n = hist.size();
        sum = 0;
        for (int i = 1; i <= 32; i++) sum += hist[n-i];
        q = sum / 32;
        if (sum < 0 && (sum % 32) != 0) q = q - 1;
        return fit(hist[n-17] - q);
    endfunction

    task automatic model_reset();
        hist.delete();
        m_count = 0;
        m_valid = 1'b0;
        m_yout  = '0;
    endtask

    task automatic drive(input logic v, input int x, input logic ordy);
        in_valid  = v;
        xin       = 16'(x);
        out_ready = ordy;
    endtask

    task automatic tick();
        logic acc, cons;
        #1;
        s_rdy = in_ready;
        m_rdy = rstn && en && !clr && (!m_valid || out_ready);
        acc   = in_valid && m_rdy;
        cons  = m_valid && out_ready;
        if (out_valid && out_ready) got_q.push_back(int'(yout));
        @(posedge clk);
        m_loaded = 1'b0;
        if (clr) begin
            hist.delete();
            m_count = 0;
            m_valid = 1'b0;
        end else begin
            if (acc) begin
                hist.push_back(int'(xin));
                if (hist.size() > 33) void'(hist.pop_front());
                m_count++;
                if (m_count > 32) begin
                    m_yout   = 16'(ref_y());
                    m_valid  = 1'b1;
                    m_loaded = 1'b1;
                    exp_q.push_back(int'(m_yout));
                end
            end
            if (!m_loaded && cons) m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        drive(0, 0, 1);
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; en = 1'b1; clr = 1'b0;
        drive(1, 123, 1);
        model_reset();
        #2;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_cmp++; if (yout !== 16'sd0) begin n_bad++; $display("FAIL reset_yout: got %0d expected 0", yout); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b expected 0", in_ready); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_constant();
        for (int i = 0; i < 40; i++) begin
            drive(1, 1000, 1);
            tick();
            n_cmp++;
            if (s_rdy !== m_rdy || out_valid !== m_valid || (m_valid && yout !== m_yout)) begin
                n_bad++;
                $display("FAIL const_lock i=%0d: got rdy=%b v=%b y=%0d, expected rdy=%b v=%b y=%0d", i, s_rdy, out_valid, yout, m_rdy, m_valid, m_yout);
            end
            n_cmp++;
            if (i < 32 && out_valid !== 1'b0) begin
                n_bad++; $display("FAIL const_fill i=%0d: got valid=%b expected 0", i, out_valid);
            end else if (i >= 32 && (out_valid !== 1'b1 || yout !== 16'sd0)) begin
                n_bad++; $display("FAIL const_zero i=%0d: got v=%b y=%0d expected v=1 y=0", i, out_valid, yout);
            end
        end
    endtask

    task automatic test_impulse();
        int e;
        do_clr();
        for (int i = 0; i < 80; i++) begin
            drive(1, (i == 40) ? 3200 : 0, 1);
            tick();
            n_cmp++;
            if (s_rdy !== m_rdy || out_valid !== m_valid || (m_valid && yout !== m_yout)) begin
                n_bad++;
                $display("FAIL imp_lock i=%0d: got v=%b y=%0d, expected v=%b y=%0d", i, out_valid, yout, m_valid, m_yout);
            end
            if (i >= 40) begin
                e = (i - 40 >= 32) ? 0 : ((i - 40 == 16) ? 3100 : -100);
                n_cmp++;
                if (out_valid !== 1'b1 || yout !== 16'(e)) begin
                    n_bad++; $display("FAIL impulse k+%0d: got y=%0d v=%b expected y=%0d v=1", i - 40, yout, out_valid, e);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_clr();
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 40; i++) begin
            drive(1, int'($urandom_range(0, 4000)) - 2000, 1);
            tick();
            n_cmp++;
            if (s_rdy !== m_rdy || out_valid !== m_valid || (m_valid && yout !== m_yout)) begin
                n_bad++; $display("FAIL bp_fill i=%0d: got v=%b y=%0d, expected v=%b y=%0d", i, out_valid, yout, m_valid, m_yout);
            end
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, int'($urandom_range(0, 4000)) - 2000, 0);
            tick();
            n_cmp++;
            if (s_rdy !== 1'b0 || out_valid !== 1'b1 || yout !== m_yout) begin
                n_bad++; $display("FAIL bp_hold i=%0d: got rdy=%b v=%b y=%0d, expected rdy=0 v=1 y=%0d", i, s_rdy, out_valid, yout, m_yout);
            end
        end
        for (int i = 0; i < 40; i++) begin
            drive(($urandom % 4) != 0, int'($urandom_range(0, 4000)) - 2000, 1'($urandom % 2));
            tick();
            n_cmp++;
            if (s_rdy !== m_rdy || out_valid !== m_valid || (m_valid && yout !== m_yout)) begin
                n_bad++; $display("FAIL bp_run i=%0d: got rdy=%b v=%b y=%0d, expected rdy=%b v=%b y=%0d", i, s_rdy, out_valid, yout, m_rdy, m_valid, m_yout);
            end
        end
        drive(0, 0, 1);
        tick();
        n_cmp++;
        if (got_q.size() != exp_q.size() || got_q != exp_q) begin
            n_bad++; $display("FAIL bp_order: got %0d samples, expected %0d in model order", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_overflow();
        do_clr();
        for (int i = 0; i < 70; i++) begin
            drive(1, (i == 40) ? 32767 : -32768, 1);
            tick();
            n_cmp++;
            if (s_rdy !== m_rdy || out_valid !== m_valid || (m_valid && yout !== m_yout)) begin
                n_bad++; $display("FAIL ovf_lock i=%0d: got v=%b y=%0d, expected v=%b y=%0d", i, out_valid, yout, m_valid, m_yout);
            end
            if (i == 56) begin
                n_cmp++;
                if (yout !== 16'(OVF_EXP)) begin
                    n_bad++; $display("FAIL overflow k+16: got %0d expected %0d", yout, OVF_EXP);
                end
            end
        end
    endtask

    task automatic test_clr();
        do_clr();
        for (int i = 0; i < 36; i++) begin
            drive(1, int'($urandom_range(0, 2000)), 1);
            tick();
        end
        clr = 1'b1;
        drive(1, 5555, 0);
        tick();
        clr = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || s_rdy !== 1'b0) begin
            n_bad++; $display("FAIL clr_drop: got v=%b rdy=%b expected v=0 rdy=0", out_valid, s_rdy);
        end
        for (int i = 0; i < 33; i++) begin
            drive(1, int'($urandom_range(0, 2000)) - 1000, 1);
            tick();
            n_cmp++;
            if (out_valid !== ((i == 32) ? 1'b1 : 1'b0) || out_valid !== m_valid || (m_valid && yout !== m_yout)) begin
                n_bad++; $display("FAIL clr_refill i=%0d: got v=%b y=%0d, expected v=%b y=%0d", i, out_valid, yout, m_valid, m_yout);
            end
        end
    endtask

    task automatic test_async_reset();
        do_clr();
        for (int i = 0; i < 40; i++) begin
            drive(1, int'($urandom_range(0, 3000)), 1);
            tick();
        end
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || yout !== 16'sd0 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL async_rst: got v=%b y=%0d rdy=%b expected v=0 y=0 rdy=0", out_valid, yout, in_ready);
        end
        model_reset();
        @(posedge clk);
        #3;
        rstn = 1'b1;
        test_constant();
    endtask

    task automatic test_random();
        do_clr();
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom % 8) != 0;
            clr = ($urandom % 40) == 0;
            drive(($urandom % 4) != 0, int'($urandom_range(0, 65535)) - 32768, 1'(($urandom % 3) != 0));
            tick();
            n_cmp++;
            if (s_rdy !== m_rdy || out_valid !== m_valid || (m_valid && yout !== m_yout)) begin
                n_bad++; $display("FAIL rand i=%0d: got rdy=%b v=%b y=%0d, expected rdy=%b v=%b y=%0d", i, s_rdy, out_valid, yout, m_rdy, m_valid, m_yout);
            end
        end
        en  = 1'b1;
        clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_constant();
        test_impulse();
        test_backpressure();
        test_overflow();
        test_clr();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
